// File: rtl/daq_sample_collector_pkg.sv
// Shared types and constants for the DAQ sample collector: FSM state
// encoding, register offsets within the control window and CTRL bit fields.
package daq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Source of the registered read response.
  typedef enum logic [1:0] {
    RD_ZERO = 2'd0,
    RD_REG  = 2'd1,
    RD_BUF  = 2'd2
  } rd_src_t;

  // Register offsets from the control base address.
  localparam int unsigned REG_CTRL   = 0;
  localparam int unsigned REG_COUNT  = 1;
  localparam int unsigned REG_STATUS = 2;

  // CTRL register bit positions.
  localparam int unsigned CTRL_START     = 0;
  localparam int unsigned CTRL_ACK       = 1;
  localparam int unsigned CTRL_CHSEL_LSB = 4;
  localparam int unsigned CHSEL_W        = 4;

endpackage

// File: rtl/daq_sample_collector_if.sv
// Host bus and sample front-end signals of the DAQ sample collector.
// Handshake: wr_en and rd_en are single-cycle strobes with no back-pressure;
// every rd_en is answered by exactly one rd_valid pulse the following cycle,
// and smp_valid marks one sample present on all channels for that cycle.
interface daq_sample_collector_if #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int CHANNELS = 4
);
  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic                       rd_en;
  logic [ADDR_W-1:0]          rd_addr;
  logic [DATA_W-1:0]          rd_data;
  logic                       rd_valid;
  logic                       smp_valid;
  logic [CHANNELS*DATA_W-1:0] smp_data;
  logic                       interrupt;
  logic                       busy;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, smp_valid, smp_data,
    input  rd_data, rd_valid, interrupt, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, smp_valid, smp_data,
    output rd_data, rd_valid, interrupt, busy
  );
endinterface

// File: rtl/daq_sample_collector_ram.sv
// Simple dual-port sample buffer: one synchronous write port and one
// registered read port. Storage is not reset; a read and a write to the
// same address in one cycle return the previously stored word.
module daq_sample_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Write the captured sample and register the read word (old data on collision).
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/daq_sample_collector.sv
// Multi-channel capture block: address decode, COUNT/CHSEL registers,
// capture FSM, channel mux and registered bus read path.
module daq_sample_collector
  import daq_pkg::*;
#(
  parameter int          DATA_W    = 16,
  parameter int          ADDR_W    = 16,
  parameter int          DEPTH     = 256,
  parameter int          CHANNELS  = 4,
  parameter int unsigned CTRL_BASE = 'h5000,
  parameter int unsigned BUF_BASE  = 'h5500
) (
  input  logic                   clk,
  input  logic                   rst,
  daq_sample_collector_if.slave  bus,
  output state_t                 dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = AW + 1;
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(CTRL_BASE + REG_CTRL);
  localparam logic [ADDR_W-1:0] A_COUNT  = ADDR_W'(CTRL_BASE + REG_COUNT);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(CTRL_BASE + REG_STATUS);
  localparam logic [ADDR_W-1:0] A_BUF    = ADDR_W'(BUF_BASE);
  localparam logic [ADDR_W-1:0] B_DEPTH  = ADDR_W'(DEPTH);

  state_t             state, state_n;
  logic [IW-1:0]      idx, idx_n, count;
  logic [CHSEL_W-1:0] chsel, chsel_n, chsel_raw, chsel_new;
  logic               irq, irq_n;
  logic               wr_ctrl, wr_count, start, ack;
  logic [DATA_W-1:0]  smp_sel;
  logic               ram_we, ram_re, buf_hit, reg_hit;
  logic [ADDR_W-1:0]  rd_off;
  logic [DATA_W-1:0]  ram_q, reg_val, rd_reg;
  rd_src_t            rd_src;

  assign wr_ctrl   = bus.wr_en && (bus.wr_addr == A_CTRL);
  assign wr_count  = bus.wr_en && (bus.wr_addr == A_COUNT);
  assign start     = wr_ctrl && bus.wr_data[CTRL_START];
  assign ack       = wr_ctrl && bus.wr_data[CTRL_ACK];
  assign chsel_raw = bus.wr_data[CTRL_CHSEL_LSB +: CHSEL_W];
  // Out-of-range channel selects fall back to channel 0.
  assign chsel_new = (32'(chsel_raw) >= CHANNELS) ? '0 : chsel_raw;

  assign bus.busy      = (state == ST_CAPTURE);
  assign bus.interrupt = irq;
  assign dbg_state     = state;

  // Select the latched channel out of the packed sample bus.
  always_comb begin
    smp_sel = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (32'(chsel) == k) smp_sel = bus.smp_data[k*DATA_W +: DATA_W];
    end
  end

  // Next-state logic: ACK is applied before START, START restarts a capture.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    chsel_n = chsel;
    ram_we  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_CAPTURE;
          idx_n   = '0;
          chsel_n = chsel_new;
        end
      end
      ST_CAPTURE: begin
        if (start) begin
          idx_n   = '0;
          chsel_n = chsel_new;
        end else if (ack) begin
          state_n = ST_IDLE;
        end else if (bus.smp_valid) begin
          ram_we = 1'b1;
          idx_n  = idx + IW'(1);
          // A lowered COUNT (<= index) also ends the capture here.
          if ((idx + IW'(1)) >= count) state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ack && start) begin
          state_n = ST_CAPTURE;
          idx_n   = '0;
          chsel_n = chsel_new;
        end else if (ack) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    irq_n = (state_n == ST_DONE);
  end

  // State, index, channel select and interrupt registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      chsel <= '0;
      irq   <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      chsel <= chsel_n;
      irq   <= irq_n;
    end
  end

  // COUNT register: zero or oversize writes saturate to a full buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= IW'(DEPTH);
    end else if (wr_count) begin
      if ((bus.wr_data == '0) || (bus.wr_data > DATA_W'(DEPTH))) count <= IW'(DEPTH);
      else count <= bus.wr_data[IW-1:0];
    end
  end

  daq_sample_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (idx[AW-1:0]),
    .wdata (smp_sel),
    .re    (ram_re),
    .raddr (rd_off[AW-1:0]),
    .rdata (ram_q)
  );

  // Read decode: buffer window offset wraps below the base, so one compare suffices.
  assign rd_off  = bus.rd_addr - A_BUF;
  assign buf_hit = (rd_off < B_DEPTH);
  assign ram_re  = bus.rd_en && buf_hit;

  // Register read mux; CTRL is write-only and reads as zero.
  always_comb begin
    reg_hit = 1'b1;
    reg_val = '0;
    if (bus.rd_addr == A_COUNT)       reg_val = DATA_W'(count);
    else if (bus.rd_addr == A_STATUS) reg_val = DATA_W'({idx, irq, state});
    else if (bus.rd_addr != A_CTRL)   reg_hit = 1'b0;
  end

  // Registered read response: valid pulse plus remembered data source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rd_valid <= 1'b0;
      rd_src       <= RD_ZERO;
      rd_reg       <= '0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        if (buf_hit) begin
          rd_src <= RD_BUF;
        end else if (reg_hit) begin
          rd_src <= RD_REG;
          rd_reg <= reg_val;
        end else begin
          rd_src <= RD_ZERO;
        end
      end
    end
  end

  // Drive read data from the registered source.
  always_comb begin
    case (rd_src)
      RD_BUF:  bus.rd_data = ram_q;
      RD_REG:  bus.rd_data = rd_reg;
      default: bus.rd_data = '0;
    endcase
  end
endmodule

// File: tb/tb_daq_sample_collector.sv
// Directed bench for daq_sample_collector: capture, readback, restart,
// abort, reset mid-capture and address decode corner cases.
module tb_daq_sample_collector;
  import daq_pkg::*;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 16;
  localparam int DEPTH    = 256;
  localparam int CHANNELS = 4;
  localparam logic [15:0] A_CTRL   = 16'h5000;
  localparam logic [15:0] A_COUNT  = 16'h5001;
  localparam logic [15:0] A_STATUS = 16'h5002;
  localparam logic [15:0] A_BUF    = 16'h5500;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  daq_sample_collector_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CHANNELS(CHANNELS)) bus ();
  state_t dbg_state;

  daq_sample_collector #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .CHANNELS  (CHANNELS),
    .CTRL_BASE ('h5000),
    .BUF_BASE  ('h5500)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_q[$];

  // ---------------- driver tasks (entered and left at a falling edge) ----------------
  task automatic idle_inputs();
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;
    bus.smp_valid = 1'b0;
    bus.smp_data  = '0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // Selected channel carries v, every other channel carries ~v.
  task automatic set_sample(input int ch, input logic [15:0] v);
    bus.smp_valid = 1'b1;
    for (int k = 0; k < CHANNELS; k++) bus.smp_data[k*DATA_W +: DATA_W] = (k == ch) ? v : ~v;
  endtask

  task automatic put_sample(input int ch, input logic [15:0] v);
    set_sample(ch, v);
    @(negedge clk);
    bus.smp_valid = 1'b0;
  endtask

  task automatic write_and_sample(input logic [15:0] a, input logic [15:0] d,
                                  input int ch, input logic [15:0] v);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    set_sample(ch, v);
    @(negedge clk);
    bus.wr_en     = 1'b0;
    bus.smp_valid = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d, output logic v);
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    @(negedge clk);
    bus.rd_en = 1'b0;
    d = bus.rd_data;
    v = bus.rd_valid;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] d;
    logic        v;
    checks++; if (bus.rd_data !== 16'h0) begin failures++; $display("FAIL reset_rd_data: got %h expected 0000", bus.rd_data); end
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid: got %b expected 0", bus.rd_valid); end
    checks++; if (bus.interrupt !== 1'b0) begin failures++; $display("FAIL reset_interrupt: got %b expected 0", bus.interrupt); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    rst = 1'b0;
    @(negedge clk);
    bus_read(A_STATUS, d, v);
    checks++; if (d !== 16'h0000 || v !== 1'b1) begin failures++; $display("FAIL reset_status: got %h/%b expected 0000/1", d, v); end
    bus_read(A_COUNT, d, v);
    checks++; if (d !== 16'h0100 || v !== 1'b1) begin failures++; $display("FAIL reset_count: got %h/%b expected 0100/1", d, v); end
  endtask

  task automatic test_basic();
    logic [15:0] d, e;
    logic        v;
    bus_write(A_COUNT, 16'h0004);
    bus_write(A_CTRL, 16'h0021);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b expected 1", bus.busy); end
    for (int i = 0; i < 4; i++) begin
      put_sample(2, 16'hA000 + 16'(i));
      exp_q.push_back(16'hA000 + 16'(i));
      checks++;
      if (bus.interrupt !== (i == 3)) begin failures++; $display("FAIL basic_irq%0d: got %b expected %b", i, bus.interrupt, (i == 3)); end
    end
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      bus_read(A_BUF + 16'(i), d, v);
      checks++; if (d !== e || v !== 1'b1) begin failures++; $display("FAIL basic_rd%0d: got %h/%b expected %h/1", i, d, v, e); end
    end
    bus_read(A_STATUS, d, v);
    checks++; if (d !== 16'h0026) begin failures++; $display("FAIL basic_status: got %h expected 0026", d); end
  endtask

  task automatic test_start_ack();
    logic [15:0] d;
    logic        v;
    bus_write(A_CTRL, 16'h0001);
    bus_read(A_STATUS, d, v);
    checks++; if (d !== 16'h0026) begin failures++; $display("FAIL start_in_done: got %h expected 0026", d); end
    bus_write(A_CTRL, 16'h0003);
    checks++; if (bus.interrupt !== 1'b0) begin failures++; $display("FAIL startack_irq: got %b expected 0", bus.interrupt); end
    bus_read(A_STATUS, d, v);
    checks++; if (d !== 16'h0001) begin failures++; $display("FAIL startack_status: got %h expected 0001", d); end
  endtask

  task automatic test_full_depth();
    logic [15:0] d;
    logic        v;
    bus_write(A_COUNT, 16'h0000);
    bus_read(A_COUNT, d, v);
    checks++; if (d !== 16'h0100) begin failures++; $display("FAIL full_count: got %h expected 0100", d); end
    bus_write(A_CTRL, 16'h0001);
    for (int i = 0; i < DEPTH; i++) begin
      put_sample(0, 16'h1000 + 16'(i));
      if (i == DEPTH - 2) begin
        checks++; if (bus.interrupt !== 1'b0) begin failures++; $display("FAIL full_irq_early: got %b expected 0", bus.interrupt); end
      end
      if (i == DEPTH - 1) begin
        checks++; if (bus.interrupt !== 1'b1) begin failures++; $display("FAIL full_irq_last: got %b expected 1", bus.interrupt); end
      end
    end
    put_sample(0, 16'hFFFF);
    bus_read(A_STATUS, d, v);
    checks++; if (d !== 16'h0806) begin failures++; $display("FAIL full_status: got %h expected 0806", d); end
    bus_read(A_BUF, d, v);
    checks++; if (d !== 16'h1000) begin failures++; $display("FAIL full_buf0: got %h expected 1000", d); end
    bus_read(A_BUF + 16'h00FF, d, v);
    checks++; if (d !== 16'h10FF) begin failures++; $display("FAIL full_buf255: got %h expected 10ff", d); end
  endtask

  task automatic test_abort();
    logic [15:0] d, e;
    logic        v;
    bus_write(A_CTRL, 16'h0002);
    checks++; if (bus.interrupt !== 1'b0) begin failures++; $display("FAIL ack_irq: got %b expected 0", bus.interrupt); end
    bus_write(A_COUNT, 16'h0008);
    bus_write(A_CTRL, 16'h0011);
    for (int i = 0; i < 3; i++) begin
      put_sample(1, 16'hB000 + 16'(i));
      exp_q.push_back(16'hB000 + 16'(i));
    end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL abort_busy_pre: got %b expected 1", bus.busy); end
    bus_write(A_CTRL, 16'h0002);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.interrupt !== 1'b0) begin failures++; $display("FAIL abort_irq: got %b expected 0", bus.interrupt); end
    bus_read(A_STATUS, d, v);
    checks++; if (d !== 16'h0018) begin failures++; $display("FAIL abort_status: got %h expected 0018", d); end
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      bus_read(A_BUF + 16'(i), d, v);
      checks++; if (d !== e) begin failures++; $display("FAIL abort_rd%0d: got %h expected %h", i, d, e); end
    end
  endtask

  task automatic test_rst_mid_capture();
    logic [15:0] d;
    logic        v;
    bus_write(A_COUNT, 16'h0014);
    bus_write(A_CTRL, 16'h0031);
    for (int i = 0; i < 10; i++) put_sample(3, 16'hC000 + 16'(i));
    rst = 1'b1;
    #1;
    checks++; if (bus.interrupt !== 1'b0) begin failures++; $display("FAIL rst_irq: got %b expected 0", bus.interrupt); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.rd_data !== 16'h0) begin failures++; $display("FAIL rst_rd_data: got %h expected 0000", bus.rd_data); end
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL rst_rd_valid: got %b expected 0", bus.rd_valid); end
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus_read(A_COUNT, d, v);
    checks++; if (d !== 16'h0100) begin failures++; $display("FAIL rst_count: got %h expected 0100", d); end
    bus_write(A_COUNT, 16'h0014);
    bus_write(A_CTRL, 16'h0031);
    for (int i = 0; i < 20; i++) begin
      put_sample(3, 16'hD000 + 16'(i));
      if (i == 18) begin
        checks++; if (bus.interrupt !== 1'b0) begin failures++; $display("FAIL rst_new_irq_early: got %b expected 0", bus.interrupt); end
      end
      if (i == 19) begin
        checks++; if (bus.interrupt !== 1'b1) begin failures++; $display("FAIL rst_new_irq: got %b expected 1", bus.interrupt); end
      end
    end
    bus_read(A_STATUS, d, v);
    checks++; if (d !== 16'h00A6) begin failures++; $display("FAIL rst_new_status: got %h expected 00a6", d); end
    bus_read(A_BUF + 16'd19, d, v);
    checks++; if (d !== 16'hD013) begin failures++; $display("FAIL rst_new_buf19: got %h expected d013", d); end
  endtask

  task automatic test_decode_and_restart();
    logic [15:0] d;
    logic        v;
    bus_write(A_CTRL, 16'h0002);
    bus_read(16'h4FFF, d, v);
    checks++; if (d !== 16'h0000 || v !== 1'b1) begin failures++; $display("FAIL rd_below: got %h/%b expected 0000/1", d, v); end
    bus_read(16'h5600, d, v);
    checks++; if (d !== 16'h0000 || v !== 1'b1) begin failures++; $display("FAIL rd_above: got %h/%b expected 0000/1", d, v); end
    bus_write(A_BUF, 16'h5A5A);
    bus_read(A_BUF, d, v);
    checks++; if (d !== 16'hD000) begin failures++; $display("FAIL buf_write_ignored: got %h expected d000", d); end
    bus_write(A_COUNT, 16'h0002);
    bus_write(A_CTRL, 16'h0001);
    put_sample(0, 16'hF000);
    write_and_sample(A_CTRL, 16'h00F1, 0, 16'h1234);
    bus_read(A_STATUS, d, v);
    checks++; if (d !== 16'h0001) begin failures++; $display("FAIL restart_status: got %h expected 0001", d); end
    put_sample(0, 16'hE000);
    checks++; if (bus.interrupt !== 1'b0) begin failures++; $display("FAIL restart_irq_early: got %b expected 0", bus.interrupt); end
    put_sample(0, 16'hE001);
    checks++; if (bus.interrupt !== 1'b1) begin failures++; $display("FAIL restart_irq: got %b expected 1", bus.interrupt); end
    bus_read(A_BUF, d, v);
    checks++; if (d !== 16'hE000) begin failures++; $display("FAIL chsel15_buf0: got %h expected e000", d); end
    bus_read(A_BUF + 16'd1, d, v);
    checks++; if (d !== 16'hE001) begin failures++; $display("FAIL chsel15_buf1: got %h expected e001", d); end
    bus_read(A_STATUS, d, v);
    checks++; if (d !== 16'h0016) begin failures++; $display("FAIL restart_done_status: got %h expected 0016", d); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_start_ack();
    test_full_depth();
    test_abort();
    test_rst_mid_capture();
    test_decode_and_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/daq_sample_collector.md
# daq_sample_collector

Parametrised multi-channel data-acquisition collector. Bus writes to a control window arm a capture. The block then stores a programmed number of samples from one selected input channel into an internal buffer and raises a level interrupt. The host reads samples back through a memory-mapped buffer window and acknowledges. It sits between the sample front-end and the host I/O bus, as the generalised successor of the fixed 256-sample, single-channel collector.

## Interface
- `DATA_W`, 16: sample width and bus data width.
- `ADDR_W`, 16: bus address width.
- `DEPTH`, 256: buffer depth in samples; power of two, 2..4096.
- `CHANNELS`, 4: number of sample input channels, 1..16.
- `CTRL_BASE`, 16'h5000: base address of the register window.
- `BUF_BASE`, 16'h5500: base address of the buffer window, DEPTH words.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `wr_en`  in  1  bus write strobe, one cycle per write.
- `wr_addr`  in  ADDR_W  bus write address.
- `wr_data`  in  DATA_W  bus write data.
- `rd_en`  in  1  bus read strobe.
- `rd_addr`  in  ADDR_W  bus read address.
- `rd_data`  out  DATA_W  read data; valid when `rd_valid` is high.
- `rd_valid`  out  1  one-cycle read response.
- `smp_valid`  in  1  new sample present on all channels this cycle.
- `smp_data`  in  CHANNELS*DATA_W  channel k at bits [k*DATA_W +: DATA_W].
- `interrupt`  out  1  capture complete, level, held until acknowledged.
- `busy`  out  1  high while in CAPTURE.

## Operation
- Registers are at offsets from CTRL_BASE; any other address in the window is ignored.
- CTRL, offset 0, write-only:
  - bit0 START: arm a capture.
  - bit1 ACK: clear interrupt or abort.
  - bits[7:4] CHSEL: latched on START; a value >= CHANNELS selects channel 0.
- COUNT, offset 1, read/write: target sample count N.
  - Write of 0 or any value > DEPTH stores DEPTH.
  - Reset value is DEPTH.
- STATUS, offset 2, read-only:
  - bits[1:0] state: IDLE=0, CAPTURE=1, DONE=2.
  - bit2 interrupt.
  - bits[15:3] index of the next sample to write.
- State machine:
  - IDLE: START moves to CAPTURE; index cleared to 0; CHSEL latched.
  - CAPTURE: each `smp_valid` cycle writes the selected channel to buffer[index] and increments index. On the write of the sample at index N-1, go to DONE and set `interrupt` in the same edge.
  - DONE: further samples are ignored. ACK moves to IDLE and clears `interrupt`.
- START during CAPTURE restarts the capture: index is set to 0 and CHSEL is re-latched. Any `smp_valid` in that same cycle is dropped.
- START during DONE is ignored until ACK.
- ACK during CAPTURE aborts to IDLE with no interrupt; buffer contents are retained.
- START and ACK in one write: ACK is applied first, then START. The result is always CAPTURE with `interrupt` low.
- COUNT write during CAPTURE takes effect immediately. If the new N is <= index, go to DONE on the next `smp_valid`.
- Buffer reads are permitted in every state:
  - In-window address returns buffer[rd_addr - BUF_BASE].
  - Register addresses return register contents.
  - Any other address returns 0, with `rd_valid` still asserted.
- A bus write inside the buffer window is ignored.

## Timing
- Reset values: `rd_data`=0, `rd_valid`=0, `interrupt`=0, `busy`=0, state IDLE, index 0, COUNT=DEPTH, CHSEL 0. Buffer contents are undefined.
- Register writes take effect at the edge where `wr_en` is sampled high. `busy` rises the following cycle.
- Reads have 1-cycle latency: `rd_data`/`rd_valid` are registered, valid the cycle after `rd_en`.
- Read and capture-write to the same buffer location in one cycle: read returns the old data.
- Throughput: one sample per cycle with back-to-back `smp_valid`. A full DEPTH capture takes DEPTH valid cycles.
- Index width is clog2(DEPTH)+1 and it never wraps. The transition to DONE occurs before overflow.
- `rst` mid-capture: immediate return to IDLE with `interrupt` low. Buffer is not cleared.

## Structure
- Package `daq_pkg` holds:
  - state enum IDLE/CAPTURE/DONE and its encoding;
  - register offsets CTRL=0, COUNT=1, STATUS=2;
  - CTRL bit positions.
- Sub-module `daq_sample_ram`: simple dual-port RAM, DEPTH x DATA_W, one synchronous write port, one registered read port. No reset on storage.
- Top level holds the address decode, registers, FSM and channel mux.

## Test plan
- Reset, then write COUNT=4 and CTRL=0x21 (ch2, START). Drive 4 valid samples 0xA000..0xA003 on ch2 -> `interrupt` rises on the edge of the 4th sample. Reads of 0x5500..0x5503 return 0xA000..0xA003, one cycle after each `rd_en`.
- COUNT=0 write, START, DEPTH continuous samples -> STATUS reads 0x0000|DONE with index DEPTH. `interrupt` is set exactly at the last sample, and an extra sample does not alter buffer[0].
- START, 3 samples, then ACK -> state IDLE, `interrupt` stays 0, `busy` falls. Buffer[0..2] are retained.
- DONE with `interrupt` high, then CTRL=0x03 (START+ACK) -> `interrupt` low, state CAPTURE, index 0.
- `rst` asserted after 10 samples of a 20-sample capture -> all outputs take reset values immediately. A new START plus 20 samples completes normally.
- Read of 0x4FFF -> `rd_data`=0 with `rd_valid`=1. CHSEL=15 with CHANNELS=4 -> channel 0 data captured.
